tlb_op_ctrl: RTL
================

// Module: tlb_op_ctrl
// PURPOSE
//  Sequences the CP0 TLB instructions TLBP/TLBR/TLBWI/TLBWR against the TLB read/write/probe ports of the mmu.
//  Latches CP0 operands, drives tlbrw_*/tlbp_* for one issue cycle, then writes results back to CP0 in a commit cycle.
//  Owns the CP0 Random counter used by TLBWR. Sits between the CP0 register file / pipeline EX stage and the mmu.
// PARAMETERS
//  TLB_ENTRIES  16                     number of TLB entries (power of 2)
//  INDEX_WIDTH  $clog2(TLB_ENTRIES)    width of tlb_index_t
// PORTS
//  clk             in   1   clock
//  resetn          in   1   asynchronous active-low reset
//  op_valid        in   1   TLB instruction request from EX stage
//  op_type         in   2   tlb_op_t: 0=TLBP 1=TLBR 2=TLBWI 3=TLBWR
//  op_ready        out  1   controller idle, request accepted this cycle if op_valid
//  op_done         out  1   one-cycle pulse in COMMIT
//  busy            out  1   state != IDLE (pipeline stall)
//  flush           in   1   pipeline flush / exception
//  cp0_index       in   32  CP0 Index
//  cp0_entry_hi    in   32  CP0 EntryHi
//  cp0_entry_lo0   in   32  CP0 EntryLo0
//  cp0_entry_lo1   in   32  CP0 EntryLo1
//  cp0_page_mask   in   32  CP0 PageMask
//  cp0_wired       in   32  CP0 Wired
//  wired_we        in   1   CP0 Wired being written this cycle
//  random_value    out  32  CP0 Random read value, zero-extended
//  cp0_index_we    out  1   write cp0_index_wdata into CP0 Index (TLBP)
//  cp0_index_wdata out  32  probe result, bit31 = P (miss)
//  cp0_tlbr_we     out  1   write EntryHi/Lo0/Lo1/PageMask from cp0_tlbr_wdata
//  cp0_tlbr_wdata  out  tlb_entry_t  entry read by TLBR
//  tlbrw_index     out  INDEX_WIDTH  TLB read/write index
//  tlbrw_we        out  1   TLB write strobe
//  tlbrw_wdata     out  tlb_entry_t  TLB write entry
//  tlbrw_rdata     in   tlb_entry_t  TLB read entry, combinational on tlbrw_index
//  tlbp_entry_hi   out  32  probe key
//  tlbp_index      in   32  probe result, combinational on tlbp_entry_hi
// BEHAVIOUR
//  Reset: state=IDLE; random = TLB_ENTRIES-1; all regs 0; op_ready=1; every other output 0 except random_value.
//  FSM IDLE -> ISSUE -> COMMIT -> IDLE. Every op takes exactly 2 cycles after acceptance.
//  Accept: IDLE & op_valid & ~flush. Latch op_type, cp0_index[INDEX_WIDTH-1:0], EntryHi, packed entry.
//   TLBWR latches random instead of cp0_index.
//  ISSUE: tlbrw_index/tlbp_entry_hi driven from latches (held through COMMIT).
//   Writes: tlbrw_we = ~flush, exactly one cycle.
//   flush in ISSUE -> IDLE; no CP0 write, no op_done.
//  COMMIT: op_done=1 and flush is ignored.
//   TLBP: cp0_index_we=1, wdata = tlbp_index.
//   TLBR: cp0_tlbr_we=1, wdata = tlbrw_rdata.
//   Writes: no CP0 write.
//  op_valid outside IDLE is ignored; the requester holds it until op_ready.
//  Random counter, INDEX_WIDTH bits, lowest rule wins:
//   - decrements every cycle;
//   - when random <= wired_eff, the next value is TLB_ENTRIES-1;
//   - wired_we -> next value TLB_ENTRIES-1;
//   - wired_eff = cp0_wired; if cp0_wired >= TLB_ENTRIES, random holds at TLB_ENTRIES-1.
//  TLBWR uses the random value sampled in the accept cycle.
//  resetn low mid-op: immediately IDLE, tlbrw_we/cp0 strobes deassert asynchronously.
// STRUCTURE
//  Shared package/header: tlb_op_t enum, tlb_entry_t, tlb_index_t, TLB_ENTRIES.
//  Shared package/header functions: pack_tlb_entry(hi, lo0, lo1, mask) and its unpack (also used by CP0).
//  Sub-module tlb_random_ctr: counter + wired logic, interface (clk, resetn, wired, wired_we, value).
// TESTING
//  TLBWI, cp0_index=5, entry E -> ISSUE: tlbrw_we=1, tlbrw_index=5, wdata=E; COMMIT: op_done=1; no CP0 strobes.
//  TLBP hit at 3, then miss -> cp0_index_wdata 0x00000003 then 0x80000000, each 2 cycles after accept.
//  TLBR index 7 returning R -> cp0_tlbr_we=1, cp0_tlbr_wdata=R in COMMIT.
//  Wired=4 from reset -> random 15,14,..,4,15; wired_we at random=9 -> 15 next; wired=20 -> random stuck 15.
//  TLBWR with flush in ISSUE -> tlbrw_we=0, no op_done, IDLE next; flush in COMMIT -> op_done still 1.
//  Back-to-back op_valid held -> accepts every 3rd cycle; resetn low in ISSUE -> tlbrw_we drops, random=15.

Source files
------------

// File: rtl/tlb_op_ctrl_pkg.sv
// Shared types and helpers for the CP0 TLB instruction sequencer.
// The entry pack/unpack helpers are also meant for the CP0 register file.
package tlb_op_ctrl_pkg;

    localparam int TLB_ENTRIES = 16;
    localparam int INDEX_WIDTH = $clog2(TLB_ENTRIES);

    typedef logic [INDEX_WIDTH-1:0] tlb_index_t;

    typedef enum logic [1:0] {
        TLB_OP_TLBP  = 2'd0,
        TLB_OP_TLBR  = 2'd1,
        TLB_OP_TLBWI = 2'd2,
        TLB_OP_TLBWR = 2'd3
    } tlb_op_t;

    typedef struct packed {
        logic [31:0] entry_hi;
        logic [31:0] entry_lo0;
        logic [31:0] entry_lo1;
        logic [31:0] page_mask;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_COMMIT = 2'd2
    } ctrl_state_t;

    localparam tlb_index_t RANDOM_MAX = tlb_index_t'(TLB_ENTRIES - 1);

    function automatic tlb_entry_t pack_tlb_entry(input logic [31:0] hi,
                                                  input logic [31:0] lo0,
                                                  input logic [31:0] lo1,
                                                  input logic [31:0] mask);
        tlb_entry_t e;
        e.entry_hi  = hi;
        e.entry_lo0 = lo0;
        e.entry_lo1 = lo1;
        e.page_mask = mask;
        return e;
    endfunction

    function automatic void unpack_tlb_entry(input  tlb_entry_t  e,
                                             output logic [31:0] hi,
                                             output logic [31:0] lo0,
                                             output logic [31:0] lo1,
                                             output logic [31:0] mask);
        hi   = e.entry_hi;
        lo0  = e.entry_lo0;
        lo1  = e.entry_lo1;
        mask = e.page_mask;
    endfunction

    function automatic logic is_write_op(input tlb_op_t op);
        return (op == TLB_OP_TLBWI) || (op == TLB_OP_TLBWR);
    endfunction

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// Controller <-> mmu TLB port bundle: indexed read/write port plus the probe port.
interface tlb_op_ctrl_if;
    import tlb_op_ctrl_pkg::*;

    tlb_index_t  tlbrw_index;
    logic        tlbrw_we;
    tlb_entry_t  tlbrw_wdata;
    tlb_entry_t  tlbrw_rdata;
    logic [31:0] tlbp_entry_hi;
    logic [31:0] tlbp_index;

    modport master (
        output tlbrw_index, tlbrw_we, tlbrw_wdata, tlbp_entry_hi,
        input  tlbrw_rdata, tlbp_index
    );

    modport slave (
        input  tlbrw_index, tlbrw_we, tlbrw_wdata, tlbp_entry_hi,
        output tlbrw_rdata, tlbp_index
    );

endinterface

// File: rtl/tlb_op_ctrl_random.sv
// CP0 Random counter: counts down each cycle and wraps to the top entry
// once it reaches the wired boundary or when Wired is rewritten.
module tlb_random_ctr
    import tlb_op_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] wired,
    input  logic        wired_we,
    output tlb_index_t  value
);

    tlb_index_t value_q;
    tlb_index_t value_d;

    // Later checks override earlier ones; an out-of-range Wired pins the counter at the top.
    always_comb begin
        value_d = value_q - tlb_index_t'(1);
        if ({{(32-INDEX_WIDTH){1'b0}}, value_q} <= wired) begin
            value_d = RANDOM_MAX;
        end
        if (wired_we) begin
            value_d = RANDOM_MAX;
        end
        if (wired >= 32'(TLB_ENTRIES)) begin
            value_d = RANDOM_MAX;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value_q <= RANDOM_MAX;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR: accept in IDLE, drive the mmu in ISSUE,
// write results back to CP0 in COMMIT.
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              op_valid,
    input  logic [1:0]        op_type,
    output logic              op_ready,
    output logic              op_done,
    output logic              busy,
    input  logic              flush,
    input  logic [31:0]       cp0_index,
    input  logic [31:0]       cp0_entry_hi,
    input  logic [31:0]       cp0_entry_lo0,
    input  logic [31:0]       cp0_entry_lo1,
    input  logic [31:0]       cp0_page_mask,
    input  logic [31:0]       cp0_wired,
    input  logic              wired_we,
    output logic [31:0]       random_value,
    output logic              cp0_index_we,
    output logic [31:0]       cp0_index_wdata,
    output logic              cp0_tlbr_we,
    output tlb_entry_t        cp0_tlbr_wdata,
    tlb_op_ctrl_if.master     tlb_bus
);

    ctrl_state_t state_q, state_d;
    tlb_op_t     op_q, op_d;
    tlb_index_t  index_q, index_d;
    tlb_entry_t  entry_q, entry_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        index_we_q, index_we_d;
    logic        tlbr_we_q, tlbr_we_d;
    logic [31:0] index_wdata_q, index_wdata_d;
    tlb_entry_t  tlbr_wdata_q, tlbr_wdata_d;
    tlb_index_t  rnd_value;
    tlb_op_t     req_op;
    logic        unused_index_bits;

    assign unused_index_bits = ^cp0_index[31:INDEX_WIDTH];
    assign req_op = tlb_op_t'(op_type);

    tlb_random_ctr u_random (
        .clk      (clk),
        .resetn   (resetn),
        .wired    (cp0_wired),
        .wired_we (wired_we),
        .value    (rnd_value)
    );

    // CP0 write data is captured at the ISSUE->COMMIT edge so every output is registered.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        index_d       = index_q;
        entry_d       = entry_q;
        done_d        = 1'b0;
        index_we_d    = 1'b0;
        tlbr_we_d     = 1'b0;
        index_wdata_d = index_wdata_q;
        tlbr_wdata_d  = tlbr_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (op_valid && !flush) begin
                    state_d = ST_ISSUE;
                    op_d    = req_op;
                    index_d = (req_op == TLB_OP_TLBWR) ? rnd_value : cp0_index[INDEX_WIDTH-1:0];
                    entry_d = pack_tlb_entry(cp0_entry_hi, cp0_entry_lo0,
                                             cp0_entry_lo1, cp0_page_mask);
                end
            end
            ST_ISSUE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_COMMIT;
                    done_d  = 1'b1;
                    if (op_q == TLB_OP_TLBP) begin
                        index_we_d    = 1'b1;
                        index_wdata_d = tlb_bus.tlbp_index;
                    end
                    if (op_q == TLB_OP_TLBR) begin
                        tlbr_we_d    = 1'b1;
                        tlbr_wdata_d = tlb_bus.tlbrw_rdata;
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            op_q          <= TLB_OP_TLBP;
            index_q       <= '0;
            entry_q       <= '0;
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
            index_we_q    <= 1'b0;
            tlbr_we_q     <= 1'b0;
            index_wdata_q <= '0;
            tlbr_wdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            index_q       <= index_d;
            entry_q       <= entry_d;
            ready_q       <= ready_d;
            done_q        <= done_d;
            index_we_q    <= index_we_d;
            tlbr_we_q     <= tlbr_we_d;
            index_wdata_q <= index_wdata_d;
            tlbr_wdata_q  <= tlbr_wdata_d;
        end
    end

    assign op_ready        = ready_q;
    assign busy            = ~ready_q;
    assign op_done         = done_q;
    assign cp0_index_we    = index_we_q;
    assign cp0_index_wdata = index_wdata_q;
    assign cp0_tlbr_we     = tlbr_we_q;
    assign cp0_tlbr_wdata  = tlbr_wdata_q;
    assign random_value    = {{(32-INDEX_WIDTH){1'b0}}, rnd_value};

    // A flush arriving during ISSUE must suppress the mmu write in that same cycle.
    assign tlb_bus.tlbrw_we      = (state_q == ST_ISSUE) && is_write_op(op_q) && !flush;
    assign tlb_bus.tlbrw_index   = index_q;
    assign tlb_bus.tlbrw_wdata   = entry_q;
    assign tlb_bus.tlbp_entry_hi = entry_q.entry_hi;

endmodule
